// File: rtl/core_pkg.sv
// Shared types and constants for the PC / branch-resolution stage.
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } br_state_t;

endpackage

// File: rtl/branch_target.sv
// Combinational target selection for control transfers in EX.
// JALR wins over JAL, which wins over a conditional branch. The JALR sum
// has bit 0 cleared, so a JALR can only be misaligned through bit 1.
module branch_target
    import core_pkg::*;
(
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            cmp_out,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    output logic            taken_o,
    output logic [XLEN-1:0] target_o,
    output logic            misaligned_o
);

    logic [XLEN-1:0] pc_rel;
    logic [XLEN-1:0] reg_rel;

    assign pc_rel  = ex_pc + ex_imm;
    assign reg_rel = ex_rs1 + ex_imm;

    // Pick the target and decide taken by transfer-type priority.
    always_comb begin
        taken_o  = 1'b0;
        target_o = pc_rel;
        if (is_jalr) begin
            taken_o  = 1'b1;
            target_o = reg_rel & ~32'h1;
        end else if (is_jal) begin
            taken_o  = 1'b1;
        end else if (is_branch) begin
            taken_o  = cmp_out;
        end
    end

    assign misaligned_o = (target_o[1:0] != 2'b00);

endmodule

// File: rtl/branch_redirect.sv
// Fetch-PC owner: resolves control transfers from EX, redirects fetch,
// flushes wrong-path IF/ID for FLUSH_CYCLES unstalled cycles, and parks
// in a sticky HALT on a misaligned target.
//
// state | meaning
// RUN   | normal sequential fetch, EX transfers may be accepted
// FLUSH | redirect issued, flush_o held until counter expires
// HALT  | misaligned target seen, frozen until reset
module branch_redirect
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            cmp_out,
    input  logic            stall,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] link_o,
    output logic            redirect_o,
    output logic            flush_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o
);

    // Counter is loaded with one less than the flush length; the exit
    // happens on the unstalled cycle where it already reads zero.
    localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

    br_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            redirect_q, redirect_d;
    logic            flush_q, flush_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] maddr_q, maddr_d;

    logic            taken;
    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            accept;

    branch_target u_target (
        .is_branch    (ex_is_branch),
        .is_jal       (ex_is_jal),
        .is_jalr      (ex_is_jalr),
        .cmp_out      (cmp_out),
        .ex_pc        (ex_pc),
        .ex_imm       (ex_imm),
        .ex_rs1       (ex_rs1),
        .taken_o      (taken),
        .target_o     (target),
        .misaligned_o (misaligned)
    );

    assign accept = (state_q == RUN) && ex_valid && !stall;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (accept && taken) state_d = misaligned ? HALT : FLUSH;
            FLUSH:   if (!stall && cnt_q == 3'd0) state_d = RUN;
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    // Next values for PC, pulse, flush counter and trap capture.
    always_comb begin
        pc_d       = pc_q;
        redirect_d = 1'b0;
        flush_d    = flush_q;
        cnt_d      = cnt_q;
        mis_d      = mis_q;
        maddr_d    = maddr_q;
        case (state_q)
            RUN: begin
                if (accept && taken && !misaligned) begin
                    pc_d       = target;
                    redirect_d = 1'b1;
                    flush_d    = 1'b1;
                    cnt_d      = CNT_LOAD;
                end else if (accept && taken) begin
                    mis_d   = 1'b1;
                    maddr_d = target;
                end else if (!stall) begin
                    pc_d = pc_q + PC_INC;
                end
            end
            FLUSH: begin
                if (!stall) begin
                    pc_d = pc_q + PC_INC;
                    if (cnt_q == 3'd0) flush_d = 1'b0;
                    else               cnt_d   = cnt_q - 3'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
            flush_q    <= 1'b0;
            cnt_q      <= 3'd0;
            mis_q      <= 1'b0;
            maddr_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            flush_q    <= flush_d;
            cnt_q      <= cnt_d;
            mis_q      <= mis_d;
            maddr_q    <= maddr_d;
        end
    end

    assign pc_o            = pc_q;
    assign link_o          = ex_pc + PC_INC;
    assign redirect_o      = redirect_q;
    assign flush_o         = flush_q;
    assign misalign_o      = mis_q;
    assign misalign_addr_o = maddr_q;

endmodule

// File: tb/tb_branch_redirect.sv
// Directed bench for branch_redirect: a per-cycle vector table followed
// by hand-written stall and asynchronous-reset sequences.
module tb_branch_redirect;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, cmp_out, stall;
    logic [31:0] ex_pc, ex_imm, ex_rs1;
    logic [31:0] pc_o, link_o, misalign_addr_o;
    logic        redirect_o, flush_o, misalign_o;

    int checks = 0;
    int errors = 0;

    branch_redirect #(
        .RESET_PC     (32'h0000_1000),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_valid        (ex_valid),
        .ex_is_branch    (ex_is_branch),
        .ex_is_jal       (ex_is_jal),
        .ex_is_jalr      (ex_is_jalr),
        .ex_pc           (ex_pc),
        .ex_imm          (ex_imm),
        .ex_rs1          (ex_rs1),
        .cmp_out         (cmp_out),
        .stall           (stall),
        .pc_o            (pc_o),
        .link_o          (link_o),
        .redirect_o      (redirect_o),
        .flush_o         (flush_o),
        .misalign_o      (misalign_o),
        .misalign_addr_o (misalign_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid, br, jal, jalr, cmp, stl;
        logic [31:0] pc, imm, rs1;
        logic [31:0] e_pc;
        logic        e_red, e_fl, e_mis;
        logic [31:0] e_maddr;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(logic v, logic b, logic j, logic jr, logic c, logic s,
                                logic [31:0] p, logic [31:0] i, logic [31:0] r,
                                logic [31:0] ep, logic er, logic ef, logic em,
                                logic [31:0] ea);
        vec_t t;
        t.valid = v; t.br = b; t.jal = j; t.jalr = jr; t.cmp = c; t.stl = s;
        t.pc = p; t.imm = i; t.rs1 = r;
        t.e_pc = ep; t.e_red = er; t.e_fl = ef; t.e_mis = em; t.e_maddr = ea;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic j, input logic jr,
                         input logic c, input logic s, input logic [31:0] p,
                         input logic [31:0] i, input logic [31:0] r);
        ex_valid = v; ex_is_branch = b; ex_is_jal = j; ex_is_jalr = jr;
        cmp_out = c; stall = s; ex_pc = p; ex_imm = i; ex_rs1 = r;
    endtask

    task automatic check_outs(input string tag, input logic [31:0] ep, input logic er,
                              input logic ef, input logic em, input logic [31:0] ea);
        chk({tag, " pc_o"}, pc_o, ep);
        chk({tag, " redirect_o"}, {31'd0, redirect_o}, {31'd0, er});
        chk({tag, " flush_o"}, {31'd0, flush_o}, {31'd0, ef});
        chk({tag, " misalign_o"}, {31'd0, misalign_o}, {31'd0, em});
        chk({tag, " misalign_addr_o"}, misalign_addr_o, ea);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            v  br jal jr cmp stl pc            imm           rs1           e_pc          red fl mis maddr
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_1004, 0, 0, 0, 32'h0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_1008, 0, 0, 0, 32'h0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_100C, 0, 0, 0, 32'h0);
        vecs[3]  = mk(1, 1, 0, 0, 1, 0, 32'h100,      32'h40,       32'h0,        32'h0000_0140, 1, 1, 0, 32'h0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0144, 0, 1, 0, 32'h0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0148, 0, 0, 0, 32'h0);
        vecs[6]  = mk(1, 1, 0, 0, 0, 0, 32'h200,      32'h80,       32'h0,        32'h0000_014C, 0, 0, 0, 32'h0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0000_014C, 0, 0, 0, 32'h0);
        vecs[8]  = mk(0, 1, 0, 0, 1, 0, 32'h700,      32'h40,       32'h0,        32'h0000_0150, 0, 0, 0, 32'h0);
        vecs[9]  = mk(1, 0, 1, 0, 0, 1, 32'h700,      32'h40,       32'h0,        32'h0000_0150, 0, 0, 0, 32'h0);
        vecs[10] = mk(1, 1, 1, 1, 1, 0, 32'h500,      32'h0,        32'h301,      32'h0000_0300, 1, 1, 0, 32'h0);
        vecs[11] = mk(1, 0, 1, 0, 0, 0, 32'h600,      32'h100,      32'h0,        32'h0000_0304, 0, 1, 0, 32'h0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0308, 0, 0, 0, 32'h0);
        vecs[13] = mk(1, 0, 1, 0, 0, 0, 32'h400,      32'hFFFF_FFC0, 32'h0,       32'h0000_03C0, 1, 1, 0, 32'h0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_03C4, 0, 1, 0, 32'h0);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_03C8, 0, 0, 0, 32'h0);
        vecs[16] = mk(1, 0, 1, 0, 0, 0, 32'h400,      32'h2,        32'h0,        32'h0000_03C8, 0, 0, 1, 32'h402);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_03C8, 0, 0, 1, 32'h402);
        vecs[18] = mk(1, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_03C8, 0, 0, 1, 32'h402);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outs("reset", 32'h0000_1000, 0, 0, 0, 32'h0);

        // Table: drive inputs, check link, clock once, check registered outputs.
        for (int k = 0; k < 19; k++) begin
            drive(vecs[k].valid, vecs[k].br, vecs[k].jal, vecs[k].jalr,
                  vecs[k].cmp, vecs[k].stl, vecs[k].pc, vecs[k].imm, vecs[k].rs1);
            #1;
            chk($sformatf("vec%0d link_o", k), link_o, vecs[k].pc + 32'd4);
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", k), vecs[k].e_pc, vecs[k].e_red,
                       vecs[k].e_fl, vecs[k].e_mis, vecs[k].e_maddr);
        end

        // Reset out of HALT without a clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        check_outs("halt_reset", 32'h0000_1000, 0, 0, 0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // JALR with wrapping sum, then stall for 3 cycles mid-FLUSH while
        // a taken JAL sits in EX.
        drive(1, 0, 0, 1, 0, 0, 32'h0, 32'h8, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        check_outs("stall_redirect", 32'h4, 1, 1, 0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 0, 0, 1, 32'h800, 32'h10, 32'h0);
            @(posedge clk); #1;
            check_outs($sformatf("stall%0d", k), 32'h4, 0, 1, 0, 32'h0);
        end
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        check_outs("stall_flush1", 32'h8, 0, 1, 0, 32'h0);
        @(posedge clk); #1;
        check_outs("stall_flush2", 32'hC, 0, 0, 0, 32'h0);

        // Reset asserted mid-FLUSH: immediate clear, no leftover flush.
        drive(1, 0, 1, 0, 0, 0, 32'h40, 32'h20, 32'h0);
        @(posedge clk); #1;
        check_outs("pre_reset_redirect", 32'h60, 1, 1, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        #3;
        rst_n = 1'b0;
        #1;
        check_outs("flush_reset", 32'h0000_1000, 0, 0, 0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_outs("post_reset1", 32'h0000_1004, 0, 0, 0, 32'h0);
        @(posedge clk); #1;
        check_outs("post_reset2", 32'h0000_1008, 0, 0, 0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_redirect.md
# branch_redirect

Program-counter owner and branch-resolution stage of the core. Consumes the taken/not-taken bit produced by the branch comparator in EX, together with the decoded control-transfer type, and computes the target. It updates the fetch PC and issues a redirect pulse plus a multi-cycle flush of wrong-path instructions in IF/ID. Misaligned targets trap into a sticky halt state.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch PC after reset
- `FLUSH_CYCLES`, 2, cycles of `flush_o` per redirect (legal range 1..7)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset; one clock, reset asynchronous and active-low
- `ex_valid`  in  1  EX holds a valid instruction
- `ex_is_branch`  in  1  conditional branch (BEQ..BGEU)
- `ex_is_jal`  in  1  JAL
- `ex_is_jalr`  in  1  JALR
- `ex_pc`  in  32  PC of EX instruction
- `ex_imm`  in  32  sign-extended immediate
- `ex_rs1`  in  32  rs1 operand (JALR base)
- `cmp_out`  in  1  branch condition from comparator (valid when `ex_is_branch`)
- `stall`  in  1  pipeline frozen this cycle
- `pc_o`  out  32  current fetch PC (registered)
- `link_o`  out  32  `ex_pc + 4`, combinational, for rd writeback
- `redirect_o`  out  1  one-cycle pulse, `pc_o` holds a new target
- `flush_o`  out  1  kill IF/ID contents
- `misalign_o`  out  1  sticky, target misaligned
- `misalign_addr_o`  out  32  offending target

## Operation
- States: RUN, FLUSH, HALT. Reset: RUN, `pc_o`=RESET_PC, all other outputs 0, flush counter 0.
- Type priority when several set: jalr > jal > branch.
- Target: jalr -> `(ex_rs1 + ex_imm) & ~32'h1`; jal/branch -> `ex_pc + ex_imm`. All adds mod 2^32, wrap silently.
- taken = jalr | jal | (branch & cmp_out). `cmp_out` ignored when not a branch.
- Accept = state RUN & `ex_valid` & !`stall`.
- RUN, accept & taken & target[1:0]==0: `pc_o`<=target, `redirect_o`<=1, `flush_o`<=1, counter<=FLUSH_CYCLES-1, -> FLUSH.
- RUN, accept & taken & target[1:0]!=0: `pc_o` holds, `misalign_o`<=1, `misalign_addr_o`<=target, -> HALT. No redirect, no flush.
- RUN, otherwise: `pc_o`<=`pc_o`+4 if !`stall`, else hold.
- FLUSH: `ex_valid` ignored (wrong path); `redirect_o` low after its single cycle; `pc_o`<=`pc_o`+4 when !`stall`; counter decrements only when !`stall`; at counter 0 with !`stall`, `flush_o`<=0, -> RUN.
- HALT: `pc_o` frozen, `misalign_o` stays 1, all inputs ignored; exit only by reset.
- `stall` does not suppress `redirect_o` already asserted; it only blocks new accepts and PC increment.

## Timing
- Accept sampled at edge N -> from N: `pc_o`=target, `redirect_o`=1 for exactly cycle N..N+1, `flush_o`=1 for FLUSH_CYCLES unstalled cycles.
- Back-to-back: earliest next accept is the first cycle back in RUN; taken branch latency 1 cycle to `pc_o`.
- Not-taken branch: identical to sequential, no flush.
- `link_o` zero-cycle combinational from `ex_pc`.
- `rst_n` low at any time (including mid-FLUSH or HALT): immediate return to reset values, no pending flush survives.

## Structure
- Shared package `core_pkg`: state enum `br_state_t` {RUN, FLUSH, HALT}, `XLEN`=32, `PC_INC`=4.
- One sub-module `branch_target`: combinational target mux/adder plus misalign check; top holds PC register, FSM, flush counter.

## Test plan
- Reset with RESET_PC=32'h0000_1000, 3 unstalled cycles -> `pc_o` 0x1000,0x1004,0x1008,0x100C; outputs 0.
- BEQ taken: `ex_pc`=0x100, `ex_imm`=0x40, `cmp_out`=1 -> next cycle `pc_o`=0x140, `redirect_o` 1 cycle, `flush_o` 2 cycles, then RUN with `pc_o`=0x148.
- BNE not taken (`cmp_out`=0) at `ex_pc`=0x200 -> no redirect/flush, `pc_o` increments by 4, `link_o`=0x204.
- JALR `ex_rs1`=0x301, `ex_imm`=0x0 -> target 0x300, redirect; JAL `ex_imm`=0x2 from 0x400 -> `misalign_o`=1, `misalign_addr_o`=0x402, `pc_o` frozen until reset.
- Redirect then `stall` high 3 cycles mid-FLUSH -> `flush_o` stays high, counter/`pc_o` frozen, flush lasts 2 unstalled cycles total; `ex_valid`+taken during FLUSH ignored.
- `rst_n` pulled low during FLUSH -> `pc_o`=RESET_PC, `flush_o`=0, `redirect_o`=0 immediately, no clock needed.
